// File: rtl/escalonador_rr.sv
// Round-robin process scheduler for the PC stage.
// Picks the next runnable process on quantum expiry or process end, emits a
// one-cycle troca pulse to load it, and parks in IDLE when nothing is runnable.
//
// state  | meaning
// IDLE   | no process owns the PC; waiting for enable and an eligible process
// RUN    | proc_atual is executing; quantum_cnt counts its retired instructions
// SWITCH | one-cycle load of hd_set into the PC stage (troca high)
module escalonador_rr #(
  parameter int NUM_PROC = 5,
  parameter int QUANTUM  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_PROC-1:0] proc_ativo,
  input  logic                instr_valid,
  input  logic                proc_fim,
  input  logic                hold,
  output logic                troca,
  output logic [9:0]          hd_set,
  output logic [9:0]          proc_atual,
  output logic [7:0]          quantum_cnt,
  output logic                ocioso
);

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

  localparam logic [7:0] Q_LAST = 8'(QUANTUM - 1);

  state_t              state, state_nx;
  logic [NUM_PROC-1:0] done, done_nx, elig;
  logic [9:0]          atual_nx, hd_nx;
  logic [7:0]          qcnt_nx;
  logic                cur_ativo, fim_eff, expiry;
  logic [10:0]         rr_pick_nx, low_pick;

  // Returns {found, id}: first set bit of e after cur in circular order,
  // cur itself last. Distance 0 is mapped to NUM_PROC so cur loses ties.
  function automatic logic [10:0] rr_pick(input logic [NUM_PROC-1:0] e,
                                          input logic [9:0] cur);
    logic [10:0] pick;
    int best;
    int d;
    pick = '0;
    best = NUM_PROC + 1;
    for (int i = 0; i < NUM_PROC; i++) begin
      d = i - int'(cur);
      if (d <= 0) d = d + NUM_PROC;
      if (e[i] && d < best) begin
        best = d;
        pick = {1'b1, 10'(i)};
      end
    end
    return pick;
  endfunction

  // Done flags after this edge; the end of the current process is folded in
  // before the search so a simultaneous expiry never reselects it.
  always_comb begin
    done_nx   = done;
    cur_ativo = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (proc_atual == 10'(i)) cur_ativo = proc_ativo[i];
      if (!hold) begin
        if (state == RUN && proc_fim && proc_atual == 10'(i)) done_nx[i] = 1'b1;
        if (!proc_ativo[i]) done_nx[i] = 1'b0;
      end
    end
    elig       = proc_ativo & ~done_nx;
    rr_pick_nx = rr_pick(elig, proc_atual);
    low_pick   = rr_pick(elig, 10'(NUM_PROC - 1));
    fim_eff    = proc_fim | ~cur_ativo;
    expiry     = instr_valid & (quantum_cnt == Q_LAST);
  end

  // Next-state and datapath updates; hold freezes everything.
  always_comb begin
    state_nx = state;
    atual_nx = proc_atual;
    hd_nx    = hd_set;
    qcnt_nx  = quantum_cnt;
    if (hold) begin
      state_nx = state;
    end else if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (low_pick[10]) begin
            state_nx = SWITCH;
            atual_nx = low_pick[9:0];
            hd_nx    = low_pick[9:0];
            qcnt_nx  = '0;
          end
        end
        SWITCH: begin
          state_nx = RUN;
          qcnt_nx  = '0;
        end
        RUN: begin
          if (fim_eff || expiry) begin
            qcnt_nx = '0;
            if (!rr_pick_nx[10]) begin
              state_nx = IDLE;
            end else if (rr_pick_nx[9:0] != proc_atual) begin
              state_nx = SWITCH;
              atual_nx = rr_pick_nx[9:0];
              hd_nx    = rr_pick_nx[9:0];
            end
          end else if (instr_valid) begin
            qcnt_nx = quantum_cnt + 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= '0;
      proc_atual  <= '0;
      hd_set      <= '0;
      quantum_cnt <= '0;
    end else begin
      state       <= state_nx;
      done        <= done_nx;
      proc_atual  <= atual_nx;
      hd_set      <= hd_nx;
      quantum_cnt <= qcnt_nx;
    end
  end

  assign troca  = (state == SWITCH) & ~hold;
  assign ocioso = (state == IDLE);

endmodule

// File: tb/tb_escalonador_rr.sv
// Self-checking bench for escalonador_rr: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_escalonador_rr;
  localparam int NP = 5;
  localparam int QT = 8;
  localparam int M_IDLE = 0, M_SW = 1, M_RUN = 2;

  logic          clk = 1'b0;
  logic          reset, enable, instr_valid, proc_fim, hold;
  logic [NP-1:0] proc_ativo;
  logic          troca, ocioso;
  logic [9:0]    hd_set, proc_atual;
  logic [7:0]    quantum_cnt;

  int errors = 0;
  int checks = 0;

  int          m_mode, m_cur, m_hd, m_q;
  bit [NP-1:0] m_done;

  always #5 clk = ~clk;

  escalonador_rr #(.NUM_PROC(NP), .QUANTUM(QT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .proc_ativo(proc_ativo),
    .instr_valid(instr_valid), .proc_fim(proc_fim), .hold(hold),
    .troca(troca), .hd_set(hd_set), .proc_atual(proc_atual),
    .quantum_cnt(quantum_cnt), .ocioso(ocioso)
  );

  task automatic model_reset();
    m_mode = M_IDLE; m_cur = 0; m_hd = 0; m_q = 0; m_done = '0;
  endtask

  // Behavioural rules: circular search from cur+1, cur itself last.
  function automatic int next_after(int cur, bit [NP-1:0] el);
    for (int k = 1; k <= NP; k++)
      if (el[(cur + k) % NP]) return (cur + k) % NP;
    return -1;
  endfunction

  task automatic model_edge(input bit en, input bit [NP-1:0] at, input bit iv,
                            input bit fim, input bit hd);
    bit [NP-1:0] el;
    int nxt;
    if (hd) return;
    if (m_mode == M_RUN && fim) m_done[m_cur] = 1'b1;
    m_done = m_done & at;
    el = at & ~m_done;
    if (!en) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      nxt = next_after(NP - 1, el);
      if (nxt >= 0) begin m_mode = M_SW; m_cur = nxt; m_hd = nxt; m_q = 0; end
    end else if (m_mode == M_SW) begin
      m_mode = M_RUN; m_q = 0;
    end else if (fim || !at[m_cur] || (iv && m_q == QT - 1)) begin
      nxt = next_after(m_cur, el);
      m_q = 0;
      if (nxt < 0) m_mode = M_IDLE;
      else if (nxt != m_cur) begin m_mode = M_SW; m_cur = nxt; m_hd = nxt; end
    end else if (iv) begin
      m_q = m_q + 1;
    end
  endtask

  task automatic step(input bit en, input bit [NP-1:0] at, input bit iv,
                      input bit fim, input bit hd);
    @(negedge clk);
    enable = en; proc_ativo = at; instr_valid = iv; proc_fim = fim; hold = hd;
    @(posedge clk);
    model_edge(en, at, iv, fim, hd);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; proc_ativo = '0;
    instr_valid = 1'b0; proc_fim = 1'b0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_troca(input bit [NP-1:0] at, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b1, at, 1'b0, 1'b0, 1'b0);
      if (troca === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (troca !== 1'b0) begin errors++; $display("FAIL reset_troca got %0b want 0", troca); end
    checks++; if (ocioso !== 1'b1) begin errors++; $display("FAIL reset_ocioso got %0b want 1", ocioso); end
    checks++; if (hd_set !== 10'd0) begin errors++; $display("FAIL reset_hd_set got %0d want 0", hd_set); end
    checks++; if (proc_atual !== 10'd0) begin errors++; $display("FAIL reset_proc_atual got %0d want 0", proc_atual); end
    checks++; if (quantum_cnt !== 8'd0) begin errors++; $display("FAIL reset_quantum got %0d want 0", quantum_cnt); end
  endtask

  task automatic test_two_procs();
    bit seen;
    do_reset();
    wait_troca(5'b00101, seen);
    checks++; if (!seen) begin errors++; $display("FAIL two_first_troca got none want pulse"); end
    checks++; if (hd_set !== 10'd0) begin errors++; $display("FAIL two_first_hd got %0d want 0", hd_set); end
    step(1, 5'b00101, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 5'b00101, 1, 0, 0);
    checks++; if (quantum_cnt !== 8'd7 || troca !== 1'b0) begin errors++; $display("FAIL two_q7 got q=%0d troca=%0b want q=7 troca=0", quantum_cnt, troca); end
    step(1, 5'b00101, 1, 0, 0);
    checks++; if (troca !== 1'b1 || hd_set !== 10'd2) begin errors++; $display("FAIL two_to2 got troca=%0b hd=%0d want 1/2", troca, hd_set); end
    step(1, 5'b00101, 0, 0, 0);
    checks++; if (troca !== 1'b0) begin errors++; $display("FAIL two_no_double got %0b want 0", troca); end
    for (int i = 0; i < 8; i++) step(1, 5'b00101, 1, 0, 0);
    checks++; if (troca !== 1'b1 || hd_set !== 10'd0) begin errors++; $display("FAIL two_to0 got troca=%0b hd=%0d want 1/0", troca, hd_set); end
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    wait_troca(5'b00001, seen);
    checks++; if (!seen || hd_set !== 10'd0) begin errors++; $display("FAIL single_first got seen=%0b hd=%0d want 1/0", seen, hd_set); end
    step(1, 5'b00001, 1, 0, 0);
    checks++; if (quantum_cnt !== 8'd0) begin errors++; $display("FAIL single_q0 got %0d want 0", quantum_cnt); end
    for (int n = 1; n <= 20; n++) begin
      step(1, 5'b00001, 1, 0, 0);
      checks++;
      if (troca !== 1'b0 || proc_atual !== 10'd0 || quantum_cnt !== 8'(n % QT)) begin
        errors++;
        $display("FAIL single_cycle n=%0d got troca=%0b atual=%0d q=%0d want 0/0/%0d", n, troca, proc_atual, quantum_cnt, n % QT);
      end
    end
  endtask

  task automatic test_fim_expiry();
    bit seen;
    do_reset();
    wait_troca(5'b01010, seen);
    checks++; if (!seen || hd_set !== 10'd1) begin errors++; $display("FAIL fim_first got seen=%0b hd=%0d want 1/1", seen, hd_set); end
    step(1, 5'b01010, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 5'b01010, 1, 0, 0);
    checks++; if (troca !== 1'b1 || hd_set !== 10'd3) begin errors++; $display("FAIL fim_to3 got troca=%0b hd=%0d want 1/3", troca, hd_set); end
    step(1, 5'b01010, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 5'b01010, 1, 0, 0);
    step(1, 5'b01010, 1, 1, 0);
    checks++; if (troca !== 1'b1 || hd_set !== 10'd1) begin errors++; $display("FAIL fim_to1 got troca=%0b hd=%0d want 1/1", troca, hd_set); end
    step(1, 5'b01010, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step(1, 5'b01010, 1, 0, 0);
      checks++;
      if (troca !== 1'b0 || proc_atual !== 10'd1) begin
        errors++;
        $display("FAIL fim_no_reselect i=%0d got troca=%0b atual=%0d want 0/1", i, troca, proc_atual);
      end
    end
  endtask

  task automatic test_hold();
    bit seen;
    do_reset();
    wait_troca(5'b00001, seen);
    step(1, 5'b00001, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 5'b00001, 1, 0, 0);
    checks++; if (quantum_cnt !== 8'd5) begin errors++; $display("FAIL hold_pre got %0d want 5", quantum_cnt); end
    for (int i = 0; i < 4; i++) begin
      step(1, 5'b00001, 1, 0, 1);
      checks++;
      if (quantum_cnt !== 8'd5 || troca !== 1'b0) begin
        errors++;
        $display("FAIL hold_frozen i=%0d got q=%0d troca=%0b want 5/0", i, quantum_cnt, troca);
      end
    end
    step(1, 5'b00001, 1, 0, 0);
    checks++; if (quantum_cnt !== 8'd6) begin errors++; $display("FAIL hold_resume got %0d want 6", quantum_cnt); end

    do_reset();
    wait_troca(5'b00011, seen);
    step(1, 5'b00011, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 5'b00011, 1, 0, 0);
    checks++; if (troca !== 1'b1 || hd_set !== 10'd1) begin errors++; $display("FAIL hold_sw_enter got troca=%0b hd=%0d want 1/1", troca, hd_set); end
    for (int i = 0; i < 2; i++) begin
      step(1, 5'b00011, 1, 0, 1);
      checks++;
      if (troca !== 1'b0 || proc_atual !== 10'd1) begin
        errors++;
        $display("FAIL hold_sw_frozen got troca=%0b atual=%0d want 0/1", troca, proc_atual);
      end
    end
    @(negedge clk);
    hold = 1'b0; instr_valid = 1'b0;
    #1;
    checks++; if (troca !== 1'b1 || hd_set !== 10'd1) begin errors++; $display("FAIL hold_sw_release got troca=%0b hd=%0d want 1/1", troca, hd_set); end
    @(posedge clk);
    model_edge(1, 5'b00011, 0, 0, 0);
    #1;
    checks++; if (troca !== 1'b0 || quantum_cnt !== 8'd0 || ocioso !== 1'b0) begin errors++; $display("FAIL hold_sw_done got troca=%0b q=%0d ocioso=%0b want 0/0/0", troca, quantum_cnt, ocioso); end
  endtask

  task automatic test_idle_reawake();
    bit seen;
    do_reset();
    wait_troca(5'b00001, seen);
    step(1, 5'b00001, 0, 0, 0);
    step(1, 5'b00001, 1, 1, 0);
    checks++; if (ocioso !== 1'b1 || troca !== 1'b0) begin errors++; $display("FAIL idle_enter got ocioso=%0b troca=%0b want 1/0", ocioso, troca); end
    for (int i = 0; i < 3; i++) begin
      step(1, 5'b00001, 0, 0, 0);
      checks++;
      if (ocioso !== 1'b1 || troca !== 1'b0) begin
        errors++;
        $display("FAIL idle_stay i=%0d got ocioso=%0b troca=%0b want 1/0", i, ocioso, troca);
      end
    end
    step(1, 5'b00000, 0, 0, 0);
    step(1, 5'b00001, 0, 0, 0);
    checks++; if (troca !== 1'b1 || hd_set !== 10'd0) begin errors++; $display("FAIL idle_reawake got troca=%0b hd=%0d want 1/0", troca, hd_set); end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    wait_troca(5'b00100, seen);
    checks++; if (!seen || hd_set !== 10'd2) begin errors++; $display("FAIL async_pre got seen=%0b hd=%0d want 1/2", seen, hd_set); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (troca !== 1'b0 || hd_set !== 10'd0 || proc_atual !== 10'd0 || ocioso !== 1'b1 || quantum_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_values got troca=%0b hd=%0d atual=%0d ocioso=%0b q=%0d want 0/0/0/1/0", troca, hd_set, proc_atual, ocioso, quantum_cnt);
    end
    proc_ativo = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 5'b00000, 0, 0, 0);
      checks++;
      if (troca !== 1'b0 || ocioso !== 1'b1) begin
        errors++;
        $display("FAIL async_quiet i=%0d got troca=%0b ocioso=%0b want 0/1", i, troca, ocioso);
      end
    end
    wait_troca(5'b00100, seen);
    checks++; if (!seen || hd_set !== 10'd2) begin errors++; $display("FAIL async_after got seen=%0b hd=%0d want 1/2", seen, hd_set); end
  endtask

  task automatic test_random();
    bit [NP-1:0] at;
    bit en, iv, fim, hd, prev_troca;
    do_reset();
    at = NP'($urandom_range(1, (1 << NP) - 1));
    prev_troca = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) at[$urandom_range(0, NP - 1)] ^= 1'b1;
      en  = ($urandom_range(0, 49) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      fim = ($urandom_range(0, 29) == 0);
      hd  = ($urandom_range(0, 9) == 0);
      step(en, at, iv, fim, hd);
      checks++;
      if (troca !== ((m_mode == M_SW) && !hd)) begin errors++; $display("FAIL rnd_troca c=%0d got %0b want %0b", c, troca, (m_mode == M_SW) && !hd); end
      checks++;
      if (ocioso !== (m_mode == M_IDLE)) begin errors++; $display("FAIL rnd_ocioso c=%0d got %0b want %0b", c, ocioso, m_mode == M_IDLE); end
      checks++;
      if (proc_atual !== 10'(m_cur) || hd_set !== 10'(m_hd)) begin errors++; $display("FAIL rnd_ids c=%0d got atual=%0d hd=%0d want %0d/%0d", c, proc_atual, hd_set, m_cur, m_hd); end
      checks++;
      if (quantum_cnt !== 8'(m_q)) begin errors++; $display("FAIL rnd_quantum c=%0d got %0d want %0d", c, quantum_cnt, m_q); end
      checks++;
      if (troca === 1'b1 && prev_troca) begin errors++; $display("FAIL rnd_double_troca c=%0d got 1 twice want single pulse", c); end
      prev_troca = (troca === 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; proc_ativo = '0;
    instr_valid = 1'b0; proc_fim = 1'b0; hold = 1'b0;
    model_reset();
    test_reset();
    test_two_procs();
    test_single();
    test_fim_expiry();
    test_hold();
    test_idle_reawake();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
